// File: rtl/alu_ex_mem_stage.sv
// rtl/alu_ex_mem_stage.sv - execute-to-memory pipeline stage with 2-entry skid buffer and overflow trap
//
// Purpose:
//   Registers the ALU result, flags and control sideband coming out of the
//   execute stage into a head/skid pair of registers. Both sides use a
//   valid/ready handshake, and InReady is a flop, so a stall from the memory
//   stage never forms a combinational path back into execute. A signed
//   overflow on a trapping op is not buffered. Instead it is captured into the
//   trap registers, and the stage stops accepting until TrapAck. Flush drops
//   every buffered entry and the current input.
//
// Optional feature macro: ALU_STAGE_PERF_EN
//   When defined, the stage builds the AcceptCount and StallCount performance
//   counters. When undefined, both outputs are tied to 0.
//
// Ports:
//   Clock, ResetN                    clock, async active-low reset
//   InValid / InReady                upstream handshake (InReady registered)
//   InResult, InZero, InOverflow,    ALU outputs
//   InCarryOut
//   InTrapOnOvf                      op traps on signed overflow
//   InRd, InRegWrite, InMemRead,     control sideband
//   InMemWrite, InStoreData
//   OutValid / OutReady              downstream handshake on the head entry
//   OutResult, OutStoreData, OutZero,
//   OutCarryOut, OutRegWrite,
//   OutMemRead, OutMemWrite, OutRd   head entry fields (held while OutValid=0)
//   Flush                            drop buffered entries and current input
//   TrapPending, TrapRd, TrapResult  trap status and captured op
//   TrapAck                          leave the trap state
//   AcceptCount, StallCount          performance counters (optional)

module alu_ex_mem_stage #(
  parameter int WIDTH = 32,
  parameter int REGW  = 5
) (
  input  logic             Clock,
  input  logic             ResetN,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] InResult,
  input  logic             InZero,
  input  logic             InOverflow,
  input  logic             InCarryOut,
  input  logic             InTrapOnOvf,
  input  logic [REGW-1:0]  InRd,
  input  logic             InRegWrite,
  input  logic             InMemRead,
  input  logic             InMemWrite,
  input  logic [WIDTH-1:0] InStoreData,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] OutResult,
  output logic [WIDTH-1:0] OutStoreData,
  output logic             OutZero,
  output logic             OutCarryOut,
  output logic             OutRegWrite,
  output logic             OutMemRead,
  output logic             OutMemWrite,
  output logic [REGW-1:0]  OutRd,
  input  logic             Flush,
  output logic             TrapPending,
  output logic [REGW-1:0]  TrapRd,
  output logic [WIDTH-1:0] TrapResult,
  input  logic             TrapAck,
  output logic [31:0]      AcceptCount,
  output logic [31:0]      StallCount
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_TRAP = 1'b1
  } state_t;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] store_data;
    logic             zero;
    logic             carry_out;
    logic             reg_write;
    logic             mem_read;
    logic             mem_write;
    logic [REGW-1:0]  rd;
  } entry_t;

  state_t           state_q, state_d;
  entry_t           head_q, head_d;
  entry_t           skid_q, skid_d;
  logic             head_valid_q, head_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic             in_ready_q, in_ready_d;
  logic [REGW-1:0]  trap_rd_q, trap_rd_d;
  logic [WIDTH-1:0] trap_result_q, trap_result_d;

  entry_t in_entry;
  logic   accept;
  logic   trap_hit;
  logic   buf_accept;
  logic   pop;

  always_comb begin
    in_entry.result     = InResult;
    in_entry.store_data = InStoreData;
    in_entry.zero       = InZero;
    in_entry.carry_out  = InCarryOut;
    in_entry.reg_write  = InRegWrite;
    in_entry.mem_read   = InMemRead;
    in_entry.mem_write  = InMemWrite;
    in_entry.rd         = InRd;
  end

  // A flushed input is treated as if it never arrived. This means it can
  // neither be buffered nor raise a trap.
  assign accept     = InValid & in_ready_q;
  assign trap_hit   = accept & InOverflow & InTrapOnOvf & ~Flush;
  assign buf_accept = accept & ~(InOverflow & InTrapOnOvf) & ~Flush;
  assign pop        = head_valid_q & OutReady;

  // Trap FSM and trap capture registers
  always_comb begin
    state_d       = state_q;
    trap_rd_d     = trap_rd_q;
    trap_result_d = trap_result_q;
    case (state_q)
      ST_RUN: begin
        if (trap_hit) begin
          state_d       = ST_TRAP;
          trap_rd_d     = InRd;
          trap_result_d = InResult;
        end
      end
      ST_TRAP: begin
        if (TrapAck) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Head/skid buffer. InReady is low whenever both slots are full, so an
  // accept never arrives while the skid slot is still occupied.
  always_comb begin
    head_d       = head_q;
    skid_d       = skid_q;
    head_valid_d = head_valid_q;
    skid_valid_d = skid_valid_q;
    if (Flush) begin
      head_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (pop) begin
      if (skid_valid_q) begin
        head_d = skid_q;
        if (buf_accept) begin
          skid_d = in_entry;
        end else begin
          skid_valid_d = 1'b0;
        end
      end else if (buf_accept) begin
        // The new entry replaces the departing head. Occupancy stays at 1.
        head_d = in_entry;
      end else begin
        head_valid_d = 1'b0;
      end
    end else if (buf_accept) begin
      if (!head_valid_q) begin
        head_d       = in_entry;
        head_valid_d = 1'b1;
      end else begin
        skid_d       = in_entry;
        skid_valid_d = 1'b1;
      end
    end
  end

  // The registered ready looks ahead at next-cycle occupancy and state.
  assign in_ready_d = ~(head_valid_d & skid_valid_d) & (state_d == ST_RUN) & ~Flush;

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state_q       <= ST_RUN;
      head_q        <= '0;
      skid_q        <= '0;
      head_valid_q  <= 1'b0;
      skid_valid_q  <= 1'b0;
      in_ready_q    <= 1'b0;
      trap_rd_q     <= '0;
      trap_result_q <= '0;
    end else begin
      state_q       <= state_d;
      head_q        <= head_d;
      skid_q        <= skid_d;
      head_valid_q  <= head_valid_d;
      skid_valid_q  <= skid_valid_d;
      in_ready_q    <= in_ready_d;
      trap_rd_q     <= trap_rd_d;
      trap_result_q <= trap_result_d;
    end
  end

  assign InReady      = in_ready_q;
  assign OutValid     = head_valid_q;
  assign OutResult    = head_q.result;
  assign OutStoreData = head_q.store_data;
  assign OutZero      = head_q.zero;
  assign OutCarryOut  = head_q.carry_out;
  assign OutRegWrite  = head_q.reg_write;
  assign OutMemRead   = head_q.mem_read;
  assign OutMemWrite  = head_q.mem_write;
  assign OutRd        = head_q.rd;
  assign TrapPending  = (state_q == ST_TRAP);
  assign TrapRd       = trap_rd_q;
  assign TrapResult   = trap_result_q;

`ifdef ALU_STAGE_PERF_EN
  logic [31:0] accept_count_q, accept_count_d;
  logic [31:0] stall_count_q, stall_count_d;

  // Both counters wrap naturally, and Flush does not affect them.
  always_comb begin
    accept_count_d = accept_count_q;
    stall_count_d  = stall_count_q;
    if (accept) begin
      accept_count_d = accept_count_q + 32'd1;
    end
    if (head_valid_q & ~OutReady) begin
      stall_count_d = stall_count_q + 32'd1;
    end
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      accept_count_q <= '0;
      stall_count_q  <= '0;
    end else begin
      accept_count_q <= accept_count_d;
      stall_count_q  <= stall_count_d;
    end
  end

  assign AcceptCount = accept_count_q;
  assign StallCount  = stall_count_q;
`else
  assign AcceptCount = 32'd0;
  assign StallCount  = 32'd0;
`endif

endmodule

// File: doc/alu_ex_mem_stage.md
Name: alu_ex_mem_stage

Overview:
- Execute-to-memory pipeline stage directly downstream of the 32-bit ripple ALU.
- Registers the ALU result, flags and control sideband into a 2-entry skid buffer with valid/ready handshake on both sides, so the memory stage can stall without a combinational ready path back into execute.
- Detects signed overflow on trapping ops, holds a trap state until acknowledged, and supports a pipeline flush.

Parameters:
- WIDTH, 32, datapath width of result and store data.
- REGW, 5, destination register index width.

Ports:
- Clock  in  1  single clock; all state on rising edge.
- ResetN  in  1  asynchronous, active-low reset.
- InValid  in  1  execute stage presents a result.
- InReady  out  1  stage can accept; registered output.
- InResult  in  WIDTH  ALU Result.
- InZero  in  1  ALU Zero.
- InOverflow  in  1  ALU Overflow.
- InCarryOut  in  1  ALU CarryOut.
- InTrapOnOvf  in  1  op is signed add/sub; overflow must trap.
- InRd  in  REGW  destination register.
- InRegWrite, InMemRead, InMemWrite  in  1 each  control sideband.
- InStoreData  in  WIDTH  store data.
- OutValid  out  1  head entry valid.
- OutReady  in  1  memory stage consumes the head.
- OutResult, OutStoreData  out  WIDTH  head entry fields.
- OutZero, OutCarryOut, OutRegWrite, OutMemRead, OutMemWrite  out  1 each  head entry fields.
- OutRd  out  REGW  head entry destination.
- Flush  in  1  discard all buffered entries and the current input.
- TrapPending  out  1  overflow trap raised, awaiting acknowledge.
- TrapRd  out  REGW  InRd of the trapping op.
- TrapResult  out  WIDTH  wrapped result of the trapping op.
- TrapAck  in  1  clears the trap.
- AcceptCount  out  32  optional counter, see Optional Feature.
- StallCount  out  32  optional counter, see Optional Feature.

Behaviour:
- Reset (ResetN=0, async): count=0, FSM=RUN, and all outputs 0, including InReady=0.
- InReady=1 from the first edge after reset release.
- Handshakes:
  - Accept = InValid & InReady.
  - Pop = OutValid & OutReady.
- Storage: head register plus skid register; occupancy 0..2.
- Latency: an entry accepted at edge N is on Out* at edge N, so OutValid is high in cycle N+1.
- Ordering: FIFO order is always preserved.
- Simultaneous pop and accept at occupancy 1: the new entry replaces the head; occupancy stays 1.
- Accept while occupancy 1 without pop: the entry goes to skid; occupancy 2.
- InReady is registered and equals (occupancy_next<2) & (FSM_next==RUN) & ~Flush.
  - InValid seen while InReady=0 is ignored, with no side effect.
- Pop at occupancy 2: skid moves to head.
- Out* fields hold their last value when OutValid=0.
- FSM states:
  - RUN: normal operation.
  - RUN->TRAP: an accept with InOverflow & InTrapOnOvf.
    - The trapping entry is NOT buffered; TrapRd/TrapResult capture it.
    - TrapPending=1 from the next cycle.
  - TRAP: InReady=0; entries already buffered continue to drain normally.
  - TRAP->RUN: TrapAck=1. TrapPending=0 and InReady=1 (if space) in the following cycle.
  - TrapAck in RUN is ignored.
- InOverflow with InTrapOnOvf=0 (unsigned ops): no trap; the entry is buffered normally.
- Flush:
  - Occupancy becomes 0 at the next edge and any same-cycle accept is discarded.
  - Has priority over accept and pop.
  - Does not change the FSM state or the trap registers.
- Flush and TrapAck in the same cycle: both take effect.
- Reset mid-operation: all entries and any pending trap are lost immediately.

Optional Feature:
- Macro: ALU_STAGE_PERF_EN.
- Defined:
  - AcceptCount increments on each accept.
  - StallCount increments on each cycle with OutValid & ~OutReady.
  - Both are 32-bit, wrap from 0xFFFFFFFF to 0, and reset to 0.
  - Neither counter is affected by Flush.
- Undefined: no counter registers are built; AcceptCount and StallCount are tied to 0.

Test Plan:
- Reset then single accept: InResult=0x0000002A, InRd=3, OutReady=1 -> OutValid=1 one cycle later with OutResult=0x2A, OutRd=3; OutValid drops next cycle.
- Backpressure: OutReady=0; send 0x11, 0x22, 0x33 -> InReady=0 after two accepts, 0x33 held by the source; release OutReady -> outputs in order 0x11, 0x22, 0x33.
- Trap: InResult=0x80000000, InOverflow=1, InTrapOnOvf=1, InRd=9 -> TrapPending=1, TrapRd=9, TrapResult=0x80000000, entry never on Out*, InReady=0; TrapAck -> InReady=1 next cycle.
- Unsigned overflow: InOverflow=1, InTrapOnOvf=0, InCarryOut=1 -> entry passes with OutCarryOut=1, TrapPending stays 0.
- Flush at occupancy 2 with InValid=1 -> OutValid=0 next cycle and the input is dropped; a subsequent accept of 0x55 emerges alone.
- ALU_STAGE_PERF_EN defined: 5 accepts and 3 stalled cycles -> AcceptCount=5, StallCount=3; macro undefined -> both read 0.
